// File: rtl/sersub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding, default width
// and the counter-width helper.
package sersub_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sersub_state_t;

    localparam int SERSUB_WIDTH = 8;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_fullsub_cell.sv
// One-bit full subtractor built from two half subtractors.
// It is purely combinational and is used once per clock by the serial controller.
module halfsubtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);
    assign d  = x ^ y;
    assign bo = ~x & y;
endmodule

module fullsub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);
    logic w_d1;
    logic w_b1;
    logic w_b2;

    halfsubtractor u_hs0 (
        .x  (x),
        .y  (y),
        .d  (w_d1),
        .bo (w_b1)
    );

    halfsubtractor u_hs1 (
        .x  (w_d1),
        .y  (bin),
        .d  (d),
        .bo (w_b2)
    );

    assign bo = w_b1 | w_b2;
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller (diff = a - b, LSB first, one bit per clock).
// Define SERSUB_SIGNED_OVF_EN to add the two's-complement overflow output ovf.
module serial_sub_ctrl
    import sersub_pkg::*;
#(
    parameter int WIDTH = SERSUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERSUB_SIGNED_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sersub_state_t    r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_diff;
    logic [CNT_W-1:0] r_cnt;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;
    logic             r_bout;
`ifdef SERSUB_SIGNED_OVF_EN
    logic             r_ovf;
`endif

    logic             w_d;
    logic             w_b;
    logic [WIDTH-1:0] w_sr_next;

    fullsub_cell u_cell (
        .x   (r_sa[0]),
        .y   (r_sb[0]),
        .bin (r_borrow),
        .d   (w_d),
        .bo  (w_b)
    );

    assign w_sr_next = {w_d, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_sr     <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_bout   <= 1'b0;
`ifdef SERSUB_SIGNED_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sa     <= a;
                        r_sb     <= b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sa     <= r_sa >> 1;
                    r_sb     <= r_sb >> 1;
                    r_sr     <= w_sr_next;
                    r_borrow <= w_b;
                    if (r_cnt == CNT_LAST) begin
                        // The counter is left at its last value; IDLE reloads it on acceptance.
                        r_diff  <= w_sr_next;
                        r_bout  <= w_b;
`ifdef SERSUB_SIGNED_OVF_EN
                        r_ovf   <= r_borrow ^ w_b;
`endif
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
`ifdef SERSUB_SIGNED_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl (WIDTH=8): arithmetic cases,
// busy/done timing, start while busy, back-to-back start and asynchronous reset.
module tb_serial_sub_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
`ifdef SERSUB_SIGNED_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERSUB_SIGNED_OVF_EN
        .ovf   (ovf),
`endif
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present operands with start high, take the accepting edge, then drop start.
    task automatic launch(input logic [7:0] va, input logic [7:0] vb);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("done_after_accept", {31'd0, done}, 32'd0);
    endtask

    // Seven more busy edges, then the completion edge with the result on the outputs.
    task automatic finish(input string tag, input logic [7:0] exp_diff, input logic exp_bout);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            check("busy_running", {31'd0, busy}, 32'd1);
            check("no_early_done", {31'd0, done}, 32'd0);
        end
        @(posedge clk); #1;
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        check({tag, "_diff"}, {24'd0, diff}, {24'd0, exp_diff});
        check({tag, "_bout"}, {31'd0, bout}, {31'd0, exp_bout});
        $display("op %s: diff=%02h bout=%0b (expected %02h %0b)", tag, diff, bout, exp_diff, exp_bout);
    endtask

    task automatic done_falls(input string tag, input logic [7:0] exp_diff);
        @(posedge clk); #1;
        check({tag, "_done_pulse_end"}, {31'd0, done}, 32'd0);
        check({tag, "_diff_held"}, {24'd0, diff}, {24'd0, exp_diff});
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_bout", {31'd0, bout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_no_start", {31'd0, busy}, 32'd0);

        launch(8'h05, 8'h03);
        finish("basic", 8'h02, 1'b0);
`ifdef SERSUB_SIGNED_OVF_EN
        check("basic_ovf", {31'd0, ovf}, 32'd0);
`endif
        done_falls("basic", 8'h02);

        launch(8'h03, 8'h05);
        finish("underflow", 8'hFE, 1'b1);
        done_falls("underflow", 8'hFE);

        launch(8'h00, 8'h01);
        finish("zero_minus_one", 8'hFF, 1'b1);
        done_falls("zero_minus_one", 8'hFF);

        launch(8'hA5, 8'hA5);
        finish("equal", 8'h00, 1'b0);
        done_falls("equal", 8'h00);

        // Start pulses during the run must not disturb captured operands.
        launch(8'h10, 8'h01);
        @(posedge clk); #1;
        @(posedge clk); #1;
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        check("ignored_start_busy", {31'd0, busy}, 32'd1);
        repeat (2) begin
            @(posedge clk); #1;
            check("ignored_start_no_done", {31'd0, done}, 32'd0);
        end
        @(posedge clk); #1;
        check("ignored_start_done", {31'd0, done}, 32'd1);
        check("ignored_start_diff", {24'd0, diff}, 32'h0F);
        check("ignored_start_bout", {31'd0, bout}, 32'd0);
        $display("op ignored_start: diff=%02h bout=%0b (expected 0f 0)", diff, bout);

        // Back-to-back: start asserted in the done cycle is accepted.
        a     = 8'h80;
        b     = 8'h01;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_done_falls", {31'd0, done}, 32'd0);
        check("b2b_busy_rises", {31'd0, busy}, 32'd1);
        finish("b2b_first", 8'h7F, 1'b0);
`ifdef SERSUB_SIGNED_OVF_EN
        check("ovf_set", {31'd0, ovf}, 32'd1);
`endif
        a     = 8'h01;
        b     = 8'h80;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b2_busy_rises", {31'd0, busy}, 32'd1);
        finish("b2b_second", 8'h81, 1'b1);
        done_falls("b2b_second", 8'h81);

        launch(8'hC3, 8'h3C);
        finish("mixed", 8'h87, 1'b0);
        done_falls("mixed", 8'h87);

        // Asynchronous reset in the middle of a run.
        launch(8'h55, 8'hAA);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        check("async_rst_diff", {24'd0, diff}, 32'd0);
        check("async_rst_bout", {31'd0, bout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("no_done_after_rst", {31'd0, done}, 32'd0);
            check("idle_after_rst", {31'd0, busy}, 32'd0);
        end
        $display("op reset_mid_run: busy=%0b done=%0b diff=%02h", busy, done, diff);

        launch(8'h05, 8'h03);
        finish("after_reset", 8'h02, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial multi-bit subtractor controller. It computes diff = a - b on WIDTH-bit unsigned operands, one bit per clock, LSB first.
- Each bit step uses a single full-subtractor cell built from two half subtractors. The controller owns operand capture, the borrow chain register, bit counting and the start/done handshake.
- It sits between a requester and the arithmetic cell, trading area for WIDTH cycles of latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when diff/bout are updated.
- diff  output  WIDTH  result a-b mod 2^WIDTH; held until the next completion.
- bout  output  1  final borrow out; 1 iff a < b unsigned.

Behaviour:
- Reset (rst_n=0, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, diff=0, bout=0.
  - Shift registers, borrow register and counter are cleared.
  - Any in-flight operation is discarded.
- States: IDLE, RUN.
- IDLE, start=1 at edge E0:
  - Latch a into sa and b into sb; borrow=0; cnt=0.
  - Go to RUN; busy=1 from E0.
- IDLE, start=0: remain in IDLE.
- RUN, each edge:
  - Cell inputs are sa[0], sb[0] and borrow.
  - d_i = sa[0]^sb[0]^borrow.
  - b_i = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&borrow).
  - Shift sa and sb right by one.
  - Shift the result register sr right, inserting d_i at the MSB.
  - borrow <= b_i; cnt <= cnt+1.
- RUN, edge where cnt==WIDTH-1 (edge E_WIDTH):
  - diff <= final sr including this bit; bout <= b_i.
  - done <= 1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency: done is high in the cycle following edge E0+WIDTH. The operation occupies WIDTH clock edges.
- start while busy=1: ignored, with no queuing and no operand change. a and b may change freely after E0.
- start=1 in the done cycle: accepted (state is IDLE). done falls at the next edge and busy rises.
- Counter width: $clog2(WIDTH). The counter never wraps, because the state returns to IDLE at WIDTH-1.
- Outputs are registered only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SERSUB_SIGNED_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - On completion, ovf <= borrow-into-MSB XOR borrow-out, i.e. two's-complement overflow of a-b.
  - ovf is updated together with diff and held until the next completion.
- Undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package sersub_pkg:
  - State encoding constants ST_IDLE=1'b0, ST_RUN=1'b1.
  - Default width constant SERSUB_WIDTH=8.
  - A counter-width helper (clog2).
- Sub-module fullsub_cell (combinational):
  - Two halfsubtractor instances plus an OR of their borrows.
  - Ports: x, y, bin, d, bo.
  - Instantiated once in serial_sub_ctrl.

Test Plan:
- Basic: after reset, a=8'h05, b=8'h03, start pulse -> busy=1 for 8 cycles; done pulse; diff=8'h02, bout=0.
- Underflow: a=8'h03, b=8'h05 -> diff=8'hFE, bout=1.
- Edge cases:
  - a=8'h00, b=8'h01 -> diff=8'hFF, bout=1.
  - a=b=8'hA5 -> diff=8'h00, bout=0.
- Start while busy: start a=8'h10, b=8'h01; at cycle 3, start=1 with a=8'hFF, b=8'hFF -> result still diff=8'h0F, bout=0. Back-to-back start in the done cycle is accepted and completes 8 cycles later.
- Reset mid-operation: assert rst_n=0 at cycle 4 of a run -> busy=0, done=0, diff=0, bout=0 immediately (asynchronous). No done pulse follows the release of reset.
- SERSUB_SIGNED_OVF_EN defined:
  - a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1, bout=0.
  - a=8'h05, b=8'h03 -> ovf=0.
